// File: rtl/matriz_leds_cfg.sv
// LED-matrix puzzle controller: runtime region map, press-to-toggle board, move
// counter, level-complete detect and a blanked multiplexed row scan.
module matriz_leds_cfg #(
  parameter int LINHAS    = 8,
  parameter int COLUNAS   = 8,
  parameter int N_BOTOES  = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 4,
  localparam int LW = $clog2(LINHAS),
  localparam int CW = $clog2(COLUNAS),
  localparam int RW = $clog2(N_BOTOES) + 1,
  localparam int AW = LW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [AW-1:0]       linhas_ativas,
  input  logic                limpar,
  input  logic                cfg_we,
  input  logic [LW-1:0]       cfg_linha,
  input  logic [CW-1:0]       cfg_coluna,
  input  logic [RW-1:0]       cfg_regiao,
  output logic                nivel_concluido,
  output logic [15:0]         jogadas,
  output logic [COLUNAS-1:0]  colunas,
  output logic [LINHAS-1:0]   linhas
);

  // state  | meaning
  // APAGA  | blanking gap: no row enabled, all columns off
  // VARRE  | row idx_q driven with its LED pattern
  typedef enum logic {APAGA, VARRE} scan_t;

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  logic [COLUNAS-1:0]  estado_q [LINHAS];
  logic [COLUNAS-1:0]  estado_d [LINHAS];
  logic [RW-1:0]       mapa_q   [LINHAS][COLUNAS];
  logic [RW-1:0]       mapa_d   [LINHAS][COLUNAS];
  logic [N_BOTOES-1:0] botoes_q, botoes_d;
  logic [N_BOTOES-1:0] prensa;
  logic [15:0]         jogadas_q, jogadas_d;
  logic                nivel_q, nivel_d;
  logic                ganho;
  int                  a_int;

  scan_t               scan_q, scan_d;
  logic [LW-1:0]       idx_q, idx_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [LINHAS-1:0]   linhas_q, linhas_d;
  logic [COLUNAS-1:0]  colunas_q, colunas_d;

  always_comb begin
    a_int = int'(linhas_ativas);
    if (a_int < 1) begin
      a_int = 1;
    end else if (a_int > LINHAS) begin
      a_int = LINHAS;
    end
  end

  // Board, move counter and map; toggles always use the map as it was before this edge.
  always_comb begin
    botoes_d  = botoes;
    prensa    = botoes & ~botoes_q;
    estado_d  = estado_q;
    jogadas_d = jogadas_q;
    mapa_d    = mapa_q;
    if (limpar) begin
      for (int r = 0; r < LINHAS; r++) begin
        estado_d[r] = '0;
      end
      jogadas_d = '0;
    end else begin
      for (int r = 0; r < LINHAS; r++) begin
        for (int c = 0; c < COLUNAS; c++) begin
          for (int k = 0; k < N_BOTOES; k++) begin
            if (prensa[k] && (mapa_q[r][c] == RW'(k))) begin
              estado_d[r][c] = ~estado_q[r][c];
            end
          end
        end
      end
      if ((|prensa) && (jogadas_q != 16'hFFFF)) begin
        jogadas_d = jogadas_q + 16'd1;
      end
    end
    if (cfg_we && (int'(cfg_linha) < LINHAS) && (int'(cfg_coluna) < COLUNAS)) begin
      mapa_d[cfg_linha][cfg_coluna] = cfg_regiao;
    end
  end

  always_comb begin
    ganho = 1'b1;
    for (int r = 0; r < LINHAS; r++) begin
      if (r < a_int) begin
        for (int c = 0; c < COLUNAS; c++) begin
          if ((int'(mapa_q[r][c]) < N_BOTOES) && !estado_q[r][c]) begin
            ganho = 1'b0;
          end
        end
      end
    end
    nivel_d = limpar ? 1'b0 : ganho;
  end

  // Scan sequencer; row outputs are built from next-state so they line up with the FSM.
  always_comb begin
    scan_d    = scan_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CNTW'(1);
    linhas_d  = '0;
    colunas_d = '1;
    case (scan_q)
      APAGA: begin
        if ((BLANK_CYC == 0) || (cnt_q == CNTW'(BLANK_CYC - 1))) begin
          scan_d = VARRE;
          cnt_d  = '0;
        end
      end
      VARRE: begin
        if (cnt_q == CNTW'(SCAN_DIV - 1)) begin
          cnt_d  = '0;
          idx_d  = ((int'(idx_q) + 1) >= a_int) ? '0 : idx_q + LW'(1);
          scan_d = (BLANK_CYC == 0) ? VARRE : APAGA;
        end
      end
      default: begin
        scan_d = APAGA;
        cnt_d  = '0;
        idx_d  = '0;
      end
    endcase
    if (scan_d == VARRE) begin
      linhas_d  = LINHAS'(1) << idx_d;
      colunas_d = ~estado_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      botoes_q  <= '0;
      jogadas_q <= '0;
      nivel_q   <= 1'b0;
      scan_q    <= APAGA;
      idx_q     <= '0;
      cnt_q     <= '0;
      linhas_q  <= '0;
      colunas_q <= '1;
      for (int r = 0; r < LINHAS; r++) begin
        estado_q[r] <= '0;
        for (int c = 0; c < COLUNAS; c++) begin
          mapa_q[r][c] <= RW'(c % N_BOTOES);
        end
      end
    end else begin
      botoes_q  <= botoes_d;
      jogadas_q <= jogadas_d;
      nivel_q   <= nivel_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      linhas_q  <= linhas_d;
      colunas_q <= colunas_d;
      estado_q  <= estado_d;
      mapa_q    <= mapa_d;
    end
  end

  assign nivel_concluido = nivel_q;
  assign jogadas         = jogadas_q;
  assign colunas         = colunas_q;
  assign linhas          = linhas_q;

endmodule

// File: tb/tb_matriz_leds_cfg.sv
// Randomised + directed bench for matriz_leds_cfg against a behavioural board/scan model.
module tb_matriz_leds_cfg;
  localparam int L = 8;
  localparam int C = 8;
  localparam int N = 8;
  localparam int SD = 3;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] botoes;
  logic [3:0] linhas_ativas;
  logic       limpar;
  logic       cfg_we;
  logic [2:0] cfg_linha;
  logic [2:0] cfg_coluna;
  logic [3:0] cfg_regiao;
  logic       nivel_concluido;
  logic [15:0] jogadas;
  logic [7:0] colunas;
  logic [7:0] linhas;

  matriz_leds_cfg #(.LINHAS(L), .COLUNAS(C), .N_BOTOES(N), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .botoes(botoes), .linhas_ativas(linhas_ativas),
    .limpar(limpar), .cfg_we(cfg_we), .cfg_linha(cfg_linha), .cfg_coluna(cfg_coluna),
    .cfg_regiao(cfg_regiao), .nivel_concluido(nivel_concluido), .jogadas(jogadas),
    .colunas(colunas), .linhas(linhas)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: board as a bit grid, map as plain integers, scan as "phase + cycles left".
  bit [7:0]   m_led [L];
  int         m_map [L][C];
  logic [7:0] m_bq;
  int         m_jog;
  bit         m_niv;
  bit         m_blank;
  int         m_left;
  int         m_row;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rows_in_play();
    int a = int'(linhas_ativas);
    if (a < 1) a = 1;
    if (a > L) a = L;
    return a;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < L; r++) begin
      m_led[r] = '0;
      for (int c = 0; c < C; c++) m_map[r][c] = c % N;
    end
    m_bq = '0; m_jog = 0; m_niv = 0;
    m_blank = 1; m_left = BC; m_row = 0;
  endtask

  task automatic model_edge();
    int a;
    bit win;
    logic [7:0] press;
    a = rows_in_play();
    press = botoes & ~m_bq;
    m_bq = botoes;
    win = 1;
    for (int r = 0; r < a; r++)
      for (int c = 0; c < C; c++)
        if (m_map[r][c] < N && !m_led[r][c]) win = 0;
    if (limpar) begin
      for (int r = 0; r < L; r++) m_led[r] = '0;
      m_jog = 0;
      m_niv = 0;
    end else begin
      m_niv = win;
      for (int r = 0; r < L; r++)
        for (int c = 0; c < C; c++)
          if (m_map[r][c] < N && press[m_map[r][c]]) m_led[r][c] = ~m_led[r][c];
      if (press != 0 && m_jog < 65535) m_jog++;
    end
    if (cfg_we) m_map[cfg_linha][cfg_coluna] = int'(cfg_regiao);
    m_left--;
    if (m_left == 0) begin
      if (m_blank) begin
        m_blank = 0; m_left = SD;
      end else begin
        m_row = (m_row + 1 >= a) ? 0 : m_row + 1;
        m_blank = 1; m_left = BC;
      end
    end
  endtask

  task automatic check_outs();
    chk("linhas", {24'd0, linhas}, m_blank ? 32'd0 : (32'd1 << m_row));
    chk("colunas", {24'd0, colunas}, m_blank ? 32'hFF : {24'd0, ~m_led[m_row]});
    chk("jogadas", {16'd0, jogadas}, m_jog);
    chk("nivel", {31'd0, nivel_concluido}, {31'd0, m_niv});
  endtask

  task automatic tick(input bit do_chk);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    if (do_chk) check_outs();
  endtask

  task automatic reset_mid_cycle();
    #2 rst_n = 0;
    #1;
    chk("rst_linhas", {24'd0, linhas}, 32'd0);
    chk("rst_colunas", {24'd0, colunas}, 32'hFF);
    chk("rst_jogadas", {16'd0, jogadas}, 32'd0);
    chk("rst_nivel", {31'd0, nivel_concluido}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    bit found;
    rst_n = 0; botoes = '0; linhas_ativas = 4'd8; limpar = 0;
    cfg_we = 0; cfg_linha = '0; cfg_coluna = '0; cfg_regiao = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_outs();
    rst_n = 1;

    botoes = 8'h08; tick(1);
    botoes = 8'h00; repeat (3) tick(1);
    botoes = 8'h08; repeat (10) tick(1);
    botoes = 8'h00; repeat (45) tick(1);
    chk("jog_hold_once", {16'd0, jogadas}, 32'd2);

    botoes = 8'h03; tick(1);
    botoes = 8'h00; repeat (20) tick(1);
    chk("jog_simul", {16'd0, jogadas}, 32'd3);
    limpar = 1; botoes = 8'h10; tick(1);
    limpar = 0; botoes = 8'h00; tick(1);
    chk("jog_clear", {16'd0, jogadas}, 32'd0);
    repeat (45) tick(1);

    botoes = 8'h01; tick(1);
    botoes = 8'h00; repeat (4) tick(1);
    reset_mid_cycle();

    linhas_ativas = 4'd8;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (!m_blank && m_row == 5) found = 1;
    end
    chk("shrink_reach_row5", {31'd0, found}, 32'd1);
    linhas_ativas = 4'd2;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (!m_blank && m_row != 5) found = 1;
    end
    chk("shrink_next_row", {24'd0, linhas}, 32'd1);
    repeat (20) tick(1);

    limpar = 1; tick(1); limpar = 0;
    cfg_we = 1;
    for (int r = 0; r < L; r++)
      for (int c = 0; c < C; c++) begin
        cfg_linha = 3'(r); cfg_coluna = 3'(c);
        cfg_regiao = (r == 0) ? 4'd2 : 4'd15;
        tick(1);
      end
    cfg_we = 0;
    linhas_ativas = 4'd1;
    limpar = 1; tick(1); limpar = 0; tick(1);
    chk("win_before", {31'd0, nivel_concluido}, 32'd0);
    botoes = 8'h04; tick(1);
    botoes = 8'h00; tick(1);
    chk("win_after", {31'd0, nivel_concluido}, 32'd1);
    linhas_ativas = 4'd8; repeat (2) tick(1);
    chk("win_unassigned_rows", {31'd0, nivel_concluido}, 32'd1);
    linhas_ativas = 4'd0; repeat (2) tick(1);
    botoes = 8'h04; tick(1);
    botoes = 8'h00; tick(1);
    chk("win_undo", {31'd0, nivel_concluido}, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) botoes = 8'($urandom);
      limpar = ($urandom_range(49) == 0);
      cfg_we = ($urandom_range(7) == 0);
      cfg_linha = 3'($urandom); cfg_coluna = 3'($urandom);
      cfg_regiao = $urandom_range(1) ? 4'd15 : 4'($urandom);
      if ($urandom_range(99) == 0) linhas_ativas = 4'($urandom);
      tick(1);
    end
    cfg_we = 0; limpar = 0; botoes = '0;

    limpar = 1; tick(1); limpar = 0; tick(1);
    for (int i = 0; i < 65534; i++) begin
      botoes = (i % 2 == 0) ? 8'h01 : 8'h02;
      tick(0);
    end
    chk("jog_fffe", {16'd0, jogadas}, 32'hFFFE);
    botoes = 8'h01; tick(1);
    chk("jog_ffff", {16'd0, jogadas}, 32'hFFFF);
    botoes = 8'h02; tick(1);
    chk("jog_sat", {16'd0, jogadas}, 32'hFFFF);

    botoes = 8'h01;
    reset_mid_cycle();
    tick(1);
    chk("press_after_reset", {16'd0, jogadas}, 32'd1);
    botoes = 8'h00; repeat (10) tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/matriz_leds_cfg.md
Name: matriz_leds_cfg

Overview:
Parametrised successor of the LED-matrix puzzle controller. Holds a LINHAS x COLUNAS board of LED states and a runtime-loadable region map that assigns each LED to one button. Each button press (rising edge) toggles its region. The block also counts moves, reports level completion over a programmable number of active rows, and drives a blanked, rate-divided multiplexed row scan to the physical matrix. It sits between the debounced button inputs/UC and the matrix pins.

Parameters:
LINHAS, 8, number of matrix rows (2..16)
COLUNAS, 8, number of matrix columns (2..16)
N_BOTOES, 8, number of buttons/regions (2..16)
SCAN_DIV, 1000, clock cycles each row is driven (>=1)
BLANK_CYC, 4, all-off clock cycles between rows (>=0)

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous reset, active-low
botoes  in  N_BOTOES  debounced, synchronised buttons, active-high level
linhas_ativas  in  clog2(LINHAS)+1  rows in play for the current level (1..LINHAS)
limpar  in  1  synchronous board clear (new level)
cfg_we  in  1  region map write strobe
cfg_linha  in  clog2(LINHAS)  map write row
cfg_coluna  in  clog2(COLUNAS)  map write column
cfg_regiao  in  RW=clog2(N_BOTOES)+1  region id; values >= N_BOTOES mean "no region"
nivel_concluido  out  1  all assigned LEDs in active rows are lit
jogadas  out  16  move counter
colunas  out  COLUNAS  column drive, active-low (0 = LED on)
linhas  out  LINHAS  one-hot row enable, active-high

Behaviour:
- Reset (rst_n=0, async):
  - estado all 0.
  - map[r][c] = c mod N_BOTOES.
  - jogadas=0, nivel_concluido=0, linhas=0, colunas=all 1.
  - Scan FSM = APAGA, row index 0, counter 0.
- Edge detect: botoes_q registered each cycle; press = botoes & ~botoes_q. Holding a button toggles only once. The first cycle after reset uses botoes_q=0.
- Toggle: on a cycle with press[k]=1, every LED with map==k flips next edge. Simultaneous presses flip their disjoint regions in the same cycle. LEDs whose region id >= N_BOTOES never toggle.
- jogadas: +1 per cycle with any press bit set, regardless of how many bits. Saturates at 16'hFFFF.
- limpar has priority over presses in the same cycle: estado=0 and jogadas=0. The map is untouched.
- Map write: cfg_we writes map[cfg_linha][cfg_coluna] next edge.
  - An out-of-range row or column is ignored.
  - A press in the same cycle uses the old map.
- Win: nivel_concluido is registered and true when every LED in rows 0..A-1 is either lit or has region >= N_BOTOES.
  - A = clamp(linhas_ativas, 1, LINHAS).
  - 1-cycle latency after estado changes; forced 0 in the cycle following limpar.
  - A board with no assigned LEDs in the active rows reports 1.
- Scan FSM:
  - APAGA: linhas=0, colunas=all 1. Hold BLANK_CYC cycles, then enter VARRE. If BLANK_CYC=0, go directly to VARRE.
  - VARRE: linhas=one-hot(idx), colunas=~estado[idx], refreshed every cycle so toggles are visible immediately. Hold SCAN_DIV cycles. Then idx = (idx+1 >= A) ? 0 : idx+1, and go to APAGA.
  - If A shrinks below idx+1 mid-row, the current row completes and idx then wraps to 0.
  - Rows >= A are never enabled.
- All outputs are registered. No combinational paths from inputs to outputs.
- Reset mid-scan or mid-press: everything returns to reset values immediately, with no partial toggle.

Test Plan:
- Reset/default map: after reset, with 8x8, pulse botoes[3] one cycle -> column 3 of all rows lit, jogadas=1. Hold botoes[3] 10 cycles -> toggles once only.
- Custom map + win: write map so row 0 cols 0-7 = region 2, others 15, linhas_ativas=1. Press botoes[2] -> nivel_concluido=1 two cycles after the press edge. Press again -> 0.
- Simultaneous/priority: with the default map, press botoes[0] and botoes[1] together -> cols 0,1 toggle, jogadas=+1. Assert limpar with a press in the same cycle -> board 0, jogadas 0.
- Scan timing: SCAN_DIV=3, BLANK_CYC=2, linhas_ativas=3 -> linhas sequence 0,0,001x3,0,0,010x3,0,0,100x3, then 001. colunas=all 1 during blanks.
- Shrink mid-scan: at idx=5 with A=8, set linhas_ativas=2 -> row 5 finishes, next enabled row is 0.
- Saturation and async reset: preload jogadas to FFFE via presses (or force), press twice -> FFFF held. Drop rst_n between edges -> outputs reset without waiting for clk.
